// File: rtl/camera_pkg.sv
// camera_pkg: shared types, reset pose and fixed-point helpers for camera_control.
//   FP_WIDTH/FP_FRAC : fixed-point word layout used by every camera datapath file
//   cam_mode_e       : mode_in encoding
//   vec3_t           : {x,y,z} packed with x in the MSBs (matches pos_out/dir_out)
//   fp_mul_sat       : Q-format multiply, floor shift, result truncated to FP_WIDTH
//   fp_add_wide      : sign-extended sum one bit wider than a word
//   fp_clamp         : saturate a wide sum to [-lim, lim]
package camera_pkg;

    localparam int FP_WIDTH = 32;
    localparam int FP_FRAC  = 16;

    typedef logic signed [FP_WIDTH-1:0] fp_t;
    typedef logic signed [FP_WIDTH:0]   fp_wide_t;

    typedef enum logic [1:0] {
        MODE_WALK     = 2'd0,
        MODE_TRANS_XY = 2'd1,
        MODE_TRANS_XZ = 2'd2,
        MODE_LOOK     = 2'd3
    } cam_mode_e;

    typedef struct packed {
        fp_t x;
        fp_t y;
        fp_t z;
    } vec3_t;

    localparam fp_t   FP_ONE    = fp_t'(1 << FP_FRAC);
    // Start pose: eye at (0, 1.0, -1.5) looking down +z.
    localparam vec3_t RESET_POS = '{x: '0, y: FP_ONE, z: fp_t'(-(3 << (FP_FRAC - 1)))};
    localparam vec3_t RESET_DIR = '{x: '0, y: '0, z: FP_ONE};

    // Full-width product, arithmetic shift (rounds toward -inf), keep low word.
    function automatic fp_t fp_mul_sat(input fp_t a, input fp_t b);
        logic signed [2*FP_WIDTH-1:0] p;
        p = a * b;
        return fp_t'(p >>> FP_FRAC);
    endfunction

    function automatic fp_wide_t fp_add_wide(input fp_t a, input fp_t b);
        return fp_wide_t'(a) + fp_wide_t'(b);
    endfunction

    function automatic fp_t fp_clamp(input fp_wide_t v, input fp_t lim);
        fp_wide_t l;
        l = fp_wide_t'(lim);
        if (v > l)
            return lim;
        else if (v < -l)
            return -lim;
        else
            return fp_t'(v);
    endfunction

endpackage

// File: rtl/fp_rotate2.sv
// fp_rotate2: combinational 2-D rotation of (a,b) by (c,s):
//   a' = a*c + b*s,  b' = -a*s + b*c   (each product floor-shifted separately)
// Ports:
//   a_in, b_in   vector components
//   c_in, s_in   cosine / signed sine of the step angle
//   a_out, b_out rotated components
module fp_rotate2
    import camera_pkg::*;
(
    input  logic signed [FP_WIDTH-1:0] a_in,
    input  logic signed [FP_WIDTH-1:0] b_in,
    input  logic signed [FP_WIDTH-1:0] c_in,
    input  logic signed [FP_WIDTH-1:0] s_in,
    output logic signed [FP_WIDTH-1:0] a_out,
    output logic signed [FP_WIDTH-1:0] b_out
);

    // Inputs are unit-scale directions, so the two-term sums cannot wrap.
    assign a_out = fp_mul_sat(a_in, c_in) + fp_mul_sat(b_in, s_in);
    assign b_out = fp_mul_sat(b_in, c_in) - fp_mul_sat(a_in, s_in);

endmodule

// File: rtl/camera_control.sv
// camera_control: turns debounced buttons and mode/speed switches into a camera
// position and view direction, published to the renderer once per frame.
// Ports:
//   clk_in, rst_n_in  clock, asynchronous active-low reset
//   btn_in[3:0]       {left, right, up, down}, level-sensitive
//   mode_in[1:0]      0 walk, 1 trans_xy, 2 trans_xz, 3 look
//   speed_in[1:0]     tick period multiplier minus one
//   frame_done_in     end-of-frame pulse; publishes the shadow pose
//   pos_out, dir_out  published {x,y,z}, x in the MSBs
//   cam_valid_out     set by the first publication, held until reset
//   moving_out        registered "shadow differs from published"
// Build option: define CAMERA_ACCEL_EN for hold-to-accelerate translation
// (step doubles every ACCEL_TICKS held ticks, up to 8x).
// FP_WIDTH/FP_FRAC must match camera_pkg; other values are rejected at elaboration.
module camera_control #(
    parameter int FP_WIDTH    = 32,
    parameter int FP_FRAC     = 16,
    parameter int TICK_CYCLES = 50_000,
    parameter int STEP        = 655,
    parameter int COS_STEP    = 65533,
    parameter int SIN_STEP    = 655,
    parameter int POS_LIMIT   = 16 << FP_FRAC,
    parameter int PITCH_LIMIT = (9 << FP_FRAC) / 10,
    parameter int ACCEL_TICKS = 256
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [3:0]            btn_in,
    input  logic [1:0]            mode_in,
    input  logic [1:0]            speed_in,
    input  logic                  frame_done_in,
    output logic [3*FP_WIDTH-1:0] pos_out,
    output logic [3*FP_WIDTH-1:0] dir_out,
    output logic                  cam_valid_out,
    output logic                  moving_out
);

    import camera_pkg::*;

    if (FP_WIDTH != camera_pkg::FP_WIDTH || FP_FRAC != camera_pkg::FP_FRAC ||
        ACCEL_TICKS < 1 || TICK_CYCLES < 1) begin : g_cfg_err
        $error("camera_control: FP_WIDTH/FP_FRAC must match camera_pkg, ACCEL_TICKS and TICK_CYCLES must be >= 1");
    end

    vec3_t       spos, sdir, spos_nxt, sdir_nxt, dpos, dir_yaw;
    vec3_t       pos_q, dir_q;
    logic        valid_q, moving_q;
    logic [31:0] cnt, tick_lim;
    logic        tick;
    logic        b_l, b_r, b_u, b_d, lr_act, ud_act;
    logic        yaw_en, pitch_en, pitch_ok;
    cam_mode_e   mode;
    fp_t         step, lr_step, ud_step;
    fp_t         cos_c, yaw_s, pitch_s;
    fp_t         yaw_x, yaw_z, pit_y, pit_z, pit_abs;

    assign {b_l, b_r, b_u, b_d} = btn_in;
    // A pair pressed together cancels; XOR keeps exactly-one-pressed.
    assign lr_act = b_l ^ b_r;
    assign ud_act = b_u ^ b_d;
    assign mode   = cam_mode_e'(mode_in);

    // Tick timer: >= rather than == so lowering speed_in mid-count fires promptly.
    assign tick_lim = 32'(TICK_CYCLES) * (32'(speed_in) + 32'd1) - 32'd1;
    assign tick     = (cnt >= tick_lim);

`ifdef CAMERA_ACCEL_EN
    localparam logic [15:0] HOLD_MAX = 16'(3 * ACCEL_TICKS);

    logic [15:0] hold, hold_lvl;
    logic [1:0]  acc_sh;

    always_comb begin
        hold_lvl = hold / 16'(ACCEL_TICKS);
        acc_sh   = (hold_lvl > 16'd3) ? 2'd3 : hold_lvl[1:0];
    end

    assign step = fp_t'(STEP) <<< acc_sh;

    // Saturates once the 8x level is reached; released buttons restart at 1x.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            hold <= '0;
        else if (tick) begin
            if (btn_in == 4'd0)
                hold <= '0;
            else if (hold < HOLD_MAX)
                hold <= hold + 16'd1;
        end
    end
`else
    assign step = fp_t'(STEP);
`endif

    assign lr_step = b_r ? step : -step;
    assign ud_step = b_u ? step : -step;

    // Translation, computed from the pre-tick direction.
    always_comb begin
        dpos = '0;
        case (mode)
            MODE_WALK: begin
                if (ud_act) begin
                    dpos.x = fp_mul_sat(ud_step, sdir.x);
                    dpos.z = fp_mul_sat(ud_step, sdir.z);
                end
            end
            MODE_TRANS_XY: begin
                if (lr_act) dpos.x = lr_step;
                if (ud_act) dpos.y = ud_step;
            end
            MODE_TRANS_XZ: begin
                if (lr_act) dpos.x = lr_step;
                if (ud_act) dpos.z = ud_step;
            end
            default: ;
        endcase
    end

    assign spos_nxt.x = fp_clamp(fp_add_wide(spos.x, dpos.x), fp_t'(POS_LIMIT));
    assign spos_nxt.y = fp_clamp(fp_add_wide(spos.y, dpos.y), fp_t'(POS_LIMIT));
    assign spos_nxt.z = fp_clamp(fp_add_wide(spos.z, dpos.z), fp_t'(POS_LIMIT));

    // Rotation: yaw first, then pitch operates on the yawed direction.
    assign cos_c    = fp_t'(COS_STEP);
    assign yaw_s    = b_l ? fp_t'(-SIN_STEP) : fp_t'(SIN_STEP);
    assign pitch_s  = b_u ? fp_t'(SIN_STEP) : fp_t'(-SIN_STEP);
    assign yaw_en   = lr_act && (mode == MODE_WALK || mode == MODE_LOOK);
    assign pitch_en = ud_act && (mode == MODE_LOOK);

    fp_rotate2 u_yaw (
        .a_in  (sdir.x),
        .b_in  (sdir.z),
        .c_in  (cos_c),
        .s_in  (yaw_s),
        .a_out (yaw_x),
        .b_out (yaw_z)
    );

    always_comb begin
        dir_yaw = sdir;
        if (yaw_en) begin
            dir_yaw.x = yaw_x;
            dir_yaw.z = yaw_z;
        end
    end

    fp_rotate2 u_pitch (
        .a_in  (dir_yaw.y),
        .b_in  (dir_yaw.z),
        .c_in  (cos_c),
        .s_in  (pitch_s),
        .a_out (pit_y),
        .b_out (pit_z)
    );

    // A pitch step that would push |y| past the limit is dropped whole.
    assign pit_abs  = pit_y[FP_WIDTH-1] ? -pit_y : pit_y;
    assign pitch_ok = pitch_en && (pit_abs <= fp_t'(PITCH_LIMIT));

    always_comb begin
        sdir_nxt = dir_yaw;
        if (pitch_ok) begin
            sdir_nxt.y = pit_y;
            sdir_nxt.z = pit_z;
        end
    end

    // Publication samples the shadow before this edge's tick update, so a
    // coincident tick shows up at the following frame.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt      <= '0;
            spos     <= RESET_POS;
            sdir     <= RESET_DIR;
            pos_q    <= RESET_POS;
            dir_q    <= RESET_DIR;
            valid_q  <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            if (tick) begin
                cnt  <= '0;
                spos <= spos_nxt;
                sdir <= sdir_nxt;
            end else begin
                cnt  <= cnt + 32'd1;
            end
            if (frame_done_in) begin
                pos_q   <= spos;
                dir_q   <= sdir;
                valid_q <= 1'b1;
            end
            moving_q <= (spos != pos_q) || (sdir != dir_q);
        end
    end

    assign pos_out       = pos_q;
    assign dir_out       = dir_q;
    assign cam_valid_out = valid_q;
    assign moving_out    = moving_q;

endmodule

// File: tb/tb_camera_control.sv
module tb_camera_control;

    localparam int     TICK = 4;
    localparam longint STEP = 655, COSV = 65533, SINV = 655;
    localparam longint LIM  = 1048576, PLIM = 58982;
    localparam logic [95:0] RST_POS = {32'h0000_0000, 32'h0001_0000, 32'hFFFE_8000};
    localparam logic [95:0] RST_DIR = {32'h0000_0000, 32'h0000_0000, 32'h0001_0000};

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [3:0]  btn_in = '0;
    logic [1:0]  mode_in = '0;
    logic [1:0]  speed_in = '0;
    logic        frame_done_in = 1'b0;
    logic [95:0] pos_out, dir_out;
    logic        cam_valid_out, moving_out;

    camera_control #(.TICK_CYCLES(TICK)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .btn_in        (btn_in),
        .mode_in       (mode_in),
        .speed_in      (speed_in),
        .frame_done_in (frame_done_in),
        .pos_out       (pos_out),
        .dir_out       (dir_out),
        .cam_valid_out (cam_valid_out),
        .moving_out    (moving_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [95:0] pos;
        logic [95:0] dir;
        logic        mov;
    } exp_t;

    exp_t   sb[$];
    int     n_chk = 0, n_pass = 0;
    // Reference camera: shadow pose, published pose, tick phase, hold length.
    longint msp[3], msd[3], mpp[3], mpd[3];
    int     mcnt, mhold;

    function automatic longint fmul(input longint a, input longint b);
        return (a * b) >>> 16;
    endfunction

    function automatic longint clamp(input longint v);
        if (v > LIM) return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    function automatic logic [95:0] pk(input longint v[3]);
        logic [31:0] a, b, c;
        a = 32'(v[0]); b = 32'(v[1]); c = 32'(v[2]);
        return {a, b, c};
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic model_reset();
        msp = '{0, 65536, -98304};
        msd = '{0, 0, 65536};
        mpp = msp;
        mpd = msd;
        mcnt = 0;
        mhold = 0;
    endtask

    task automatic rot_yaw(input longint h);
        longint sg, nx, nz;
        sg = h * SINV;
        nx = fmul(msd[0], COSV) + fmul(msd[2], sg);
        nz = fmul(msd[2], COSV) - fmul(msd[0], sg);
        msd[0] = nx;
        msd[2] = nz;
    endtask

    task automatic rot_pitch(input longint v);
        longint sg, ny, nz;
        sg = v * SINV;
        ny = fmul(msd[1], COSV) + fmul(msd[2], sg);
        nz = fmul(msd[2], COSV) - fmul(msd[1], sg);
        if (ny <= PLIM && ny >= -PLIM) begin
            msd[1] = ny;
            msd[2] = nz;
        end
    endtask

    // One clock edge of behaviour, using the inputs currently driven.
    task automatic model_edge();
        exp_t   e;
        longint s, h, v;
        if (frame_done_in) begin
            e.pos = pk(msp);
            e.dir = pk(msd);
            e.mov = (pk(msp) != pk(mpp)) || (pk(msd) != pk(mpd));
            sb.push_back(e);
            mpp = msp;
            mpd = msd;
        end
        if (mcnt < TICK * (int'(speed_in) + 1) - 1) begin
            mcnt++;
            return;
        end
        mcnt = 0;
        s = STEP;
`ifdef CAMERA_ACCEL_EN
        s = STEP << ((mhold / 256 > 3) ? 3 : mhold / 256);
        mhold = (btn_in == 4'd0) ? 0 : ((mhold < 768) ? mhold + 1 : mhold);
`endif
        h = longint'(btn_in[2]) - longint'(btn_in[3]);
        v = longint'(btn_in[1]) - longint'(btn_in[0]);
        case (mode_in)
            2'd0: begin
                if (v != 0) begin
                    msp[0] = clamp(msp[0] + fmul(v * s, msd[0]));
                    msp[2] = clamp(msp[2] + fmul(v * s, msd[2]));
                end
                if (h != 0) rot_yaw(h);
            end
            2'd1: begin
                msp[0] = clamp(msp[0] + h * s);
                msp[1] = clamp(msp[1] + v * s);
            end
            2'd2: begin
                msp[0] = clamp(msp[0] + h * s);
                msp[2] = clamp(msp[2] + v * s);
            end
            default: begin
                if (h != 0) rot_yaw(h);
                if (v != 0) rot_pitch(v);
            end
        endcase
    endtask

    task automatic cyc(input logic [3:0] b, input logic [1:0] m, input logic [1:0] sp, input logic fd);
        @(negedge clk_in);
        btn_in = b; mode_in = m; speed_in = sp; frame_done_in = fd;
        model_edge();
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n_in = 1'b0; btn_in = '0; frame_done_in = 1'b0;
        model_reset();
        #2;
        chk("rst_pos", pos_out, RST_POS);
        chk("rst_dir", dir_out, RST_DIR);
        chk("rst_valid", 96'(cam_valid_out), 96'd0);
        chk("rst_moving", 96'(moving_out), 96'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        model_edge();
    endtask

    // Monitor: every publication edge pops one expected pose.
    initial begin : mon
        exp_t e;
        logic fd;
        logic signed [31:0] dy;
        forever begin
            @(posedge clk_in);
            fd = frame_done_in && rst_n_in;
            #1;
            if (fd) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL scoreboard: publication seen, no expected entry");
                end else begin
                    e = sb.pop_front();
                    chk("pos_out", pos_out, e.pos);
                    chk("dir_out", dir_out, e.dir);
                    chk("moving_out", 96'(moving_out), 96'(e.mov));
                    chk("cam_valid_out", 96'(cam_valid_out), 96'd1);
                    dy = $signed(dir_out[63:32]);
                    chk("pitch_limit", 96'(dy <= 58982 && dy >= -58982), 96'd1);
                end
            end
        end
    end

    initial begin
        logic [3:0] b;
        logic [1:0] m, sp;
        int len;

        // Idle frame after reset shows the start pose.
        do_reset();
        repeat (3) cyc(4'b0000, 2'd0, 2'd0, 1'b0);
        cyc(4'b0000, 2'd0, 2'd0, 1'b1);
        repeat (2) cyc(4'b0000, 2'd0, 2'd0, 1'b0);

        // trans_xy: right held for exactly 10 ticks from a fresh count.
        do_reset();
        repeat (39) cyc(4'b0100, 2'd1, 2'd0, 1'b0);
        cyc(4'b0000, 2'd1, 2'd0, 1'b1);

        // walk forward at speed 1.
        repeat (60) cyc(4'b0010, 2'd0, 2'd1, 1'b0);
        cyc(4'b0000, 2'd0, 2'd1, 1'b1);

        // look: pitch up into the limit, then yaw while still pressing up.
        for (int k = 0; k < 15; k++) begin
            repeat (50) cyc(4'b0010, 2'd3, 2'd0, 1'b0);
            cyc(4'b0010, 2'd3, 2'd0, 1'b1);
        end
        repeat (40) cyc(4'b1010, 2'd3, 2'd0, 1'b0);
        cyc(4'b0000, 2'd3, 2'd0, 1'b1);
        repeat (80) cyc(4'b0001, 2'd3, 2'd0, 1'b0);
        cyc(4'b0000, 2'd3, 2'd0, 1'b1);

        // trans_xz: drive z into the positive clamp and hold it there.
        for (int k = 0; k < 16; k++) begin
            repeat (500) cyc(4'b0010, 2'd2, 2'd0, 1'b0);
            cyc(4'b0010, 2'd2, 2'd0, 1'b1);
        end

        // Tick and frame pulse on the same cycle.
        do_reset();
        repeat (2) cyc(4'b0100, 2'd1, 2'd0, 1'b0);
        cyc(4'b0100, 2'd1, 2'd0, 1'b1);
        repeat (3) cyc(4'b0000, 2'd1, 2'd0, 1'b0);
        cyc(4'b0000, 2'd1, 2'd0, 1'b1);

        // Reset in the middle of activity.
        repeat (30) cyc(4'b1010, 2'd3, 2'd1, 1'b0);
        do_reset();

        // Random mode/speed/button segments with sporadic frame pulses.
        for (int k = 0; k < 250; k++) begin
            m   = 2'($urandom_range(0, 3));
            sp  = 2'($urandom_range(0, 3));
            b   = 4'($urandom);
            len = $urandom_range(1, 40);
            repeat (len) cyc(b, m, sp, ($urandom_range(0, 7) == 0));
        end

        repeat (5) cyc(4'b0000, 2'd0, 2'd0, 1'b0);
        cyc(4'b0000, 2'd0, 2'd0, 1'b1);
        repeat (3) cyc(4'b0000, 2'd0, 2'd0, 1'b0);
        @(posedge clk_in);
        #2;
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: %0d expected publications never seen", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/camera_control.md
# camera_control

Parametrised successor to the first-generation user-input camera block. It converts the four push-buttons and switch settings into a camera position and view direction for the ray marcher. It adds a pitch/yaw mode, per-axis position saturation, optional hold-to-accelerate, and frame-synchronous publication. It sits between the debounced board inputs and the render core, which samples `pos_out`/`dir_out` only when `cam_valid_out` is high.

## Interface
Parameters:
- `FP_WIDTH`, 32: signed fixed-point word width.
- `FP_FRAC`, 16: fractional bits; 1.0 = 2^FP_FRAC.
- `TICK_CYCLES`, 50_000: base cycles per update tick (1 ms at 50 MHz).
- `STEP`, 655: translation step per tick (0.01 in Q16).
- `COS_STEP`, 65533 and `SIN_STEP`, 655: rotation constants for one angular step.
- `POS_LIMIT`, 16·2^FP_FRAC: position saturation magnitude, per axis.
- `PITCH_LIMIT`, 0.9·2^FP_FRAC: maximum |dir.y|.
- `ACCEL_TICKS`, 256: held ticks per acceleration doubling.

Ports:
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  reset, asynchronous assert, active-low.
- `btn_in`  in  4  {left, right, up, down}, already debounced, level-sensitive.
- `mode_in`  in  2  0 walk, 1 trans_xy, 2 trans_xz, 3 look (pitch/yaw).
- `speed_in`  in  2  tick period multiplier minus one.
- `frame_done_in`  in  1  one-cycle pulse from the renderer at end of frame.
- `pos_out`  out  3·FP_WIDTH  published position {x,y,z}, x in MSBs.
- `dir_out`  out  3·FP_WIDTH  published direction {x,y,z}.
- `cam_valid_out`  out  1  high once the first frame-synchronous publication has occurred.
- `moving_out`  out  1  high on any cycle where the shadow state differs from the published state.

## Operation
- The block keeps internal shadow registers `spos`/`sdir`. The outputs hold a published copy.
- Tick: the counter increments each cycle. When `cnt >= TICK_CYCLES·(speed_in+1) − 1`, a tick fires and the counter clears. The `>=` compare makes a speed decrease mid-count fire on the next cycle.
- A button pair where both buttons are pressed (l&r, or u&d) is ignored for that axis.
- Modes, one update per tick, using step `S` (see Configuration):
  - walk: u/d moves `spos.x,z ± S·sdir.x,z`. l/r yaws `sdir` in the xz plane (x' = x·c + z·s, z' = −x·s + z·c, with s = −SIN_STEP for left).
  - trans_xy: l/r moves x ±S; u/d moves y ±S.
  - trans_xz: l/r moves x ±S; u/d moves z ±S.
  - look: l/r yaws as in walk. u/d pitches in the yz plane (y' = y·c + z·s, z' = −y·s + z·c).
    - If the result has |y'| > PITCH_LIMIT, the pitch update is discarded; yaw still applies.
- Multiply: full 2·FP_WIDTH signed product, arithmetic shift right by FP_FRAC (rounds toward −∞), truncated to FP_WIDTH.
- Every position result is saturated to [−POS_LIMIT, POS_LIMIT] before being stored. Intermediate sums use FP_WIDTH+1 bits so overflow cannot occur before the clamp.
- Publication: on a `frame_done_in` cycle, the outputs take the shadow values from the start of that cycle, and `cam_valid_out` is set to 1 and stays set until reset.
- If a tick and `frame_done_in` occur on the same cycle, the pre-tick shadow is published. The tick result appears at the next frame.
- A mode change mid-count takes effect on the next tick. Direction state is kept across mode changes.

## Timing
- Reset (asynchronous, while `rst_n_in`=0):
  - `spos` and `pos_out` = (0, 1.0, −1.5); `sdir` and `dir_out` = (0, 0, 1.0).
  - Counter = 0, hold counter = 0, `cam_valid_out` = 0, `moving_out` = 0.
- Button-to-shadow latency: at most one tick period. The shadow updates on the clock edge of the tick cycle.
- Shadow-to-output latency: the edge at the end of the next `frame_done_in` cycle.
- `moving_out` is registered and reflects the compare one cycle late.
- Reset asserted mid-tick or mid-frame discards all shadow changes. Counting restarts from 0 after reset release.

## Configuration
- `CAMERA_ACCEL_EN` defined:
  - A hold counter increments on each tick where any button is pressed and clears on a tick where none is pressed.
  - The step is `S = STEP << min(hold/ACCEL_TICKS, 3)`, giving 1×, 2×, 4× or 8×.
  - Acceleration applies to translation only. Rotation step is unaffected.
- `CAMERA_ACCEL_EN` undefined: `S = STEP` always; the hold counter is not built.

## Structure
- Shared package `camera_pkg`:
  - mode enum `cam_mode_e`;
  - reset-pose constants;
  - functions `fp_mul_sat` and `fp_clamp`, parametrised via package-level FP_WIDTH/FP_FRAC consistent with `types.svh`.
- Sub-module `fp_rotate2`: purely combinational 2-D rotation of (a,b) by (c,s), instantiated twice (yaw, pitch).

## Test plan
Defaults, with TICK_CYCLES=4 for simulation.
1. Reset then release, no buttons, one `frame_done_in` pulse:
   - `pos_out` = (0, 65536, −98304), `dir_out` = (0, 0, 65536);
   - `cam_valid_out` rises one cycle after the pulse.
2. trans_xy, speed 0, right held for 10 ticks, then frame pulse: `pos_out.x` = 6550, y and z unchanged.
3. walk, up held, speed 1: first shadow update occurs 8 cycles after release; `spos.z` advances by 655 each tick.
4. look, up held repeatedly:
   - |dir.y| never exceeds 58982;
   - further up presses leave `sdir` unchanged while left still yaws.
5. trans_xz, z pushed past the limit: `spos.z` saturates at 1048576 and stays there.
6. Tick coinciding with `frame_done_in`: the output shows the pre-tick value, and the following pulse shows the updated one. With `CAMERA_ACCEL_EN`, after 256 held ticks the step becomes 1310.
